// File: rtl/cordic_pipe_sched.sv
// cordic_pipe_sched: issue scheduler for the pipelined CORDIC datapath.
// Arbitrates two requesters round-robin, drives the angle ROM address,
// registers {wen,qua,cor} into the ROM buffer one cycle later, tracks
// in-flight tokens to the pipe output and throttles with downstream credits.
// Optional: define CSCHED_PERF_EN to add the stall_cnt performance counter.
module cordic_pipe_sched #(
  parameter int PIPE_LAT = 12,
  parameter int CREDITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_qua,
  input  logic [6:0]  req0_cor,
  input  logic        req0_wen,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_qua,
  input  logic [6:0]  req1_cor,
  input  logic        req1_wen,
  input  logic        flush,
  output logic        rom_en,
  output logic [9:0]  rom_addr,
  output logic        buf_wen,
  output logic [2:0]  buf_qua,
  output logic [6:0]  buf_cor,
  output logic        res_valid,
  output logic        res_src,
  input  logic        res_pop,
  output logic [3:0]  credits,
  output logic        busy,
  output logic        flush_done
`ifdef CSCHED_PERF_EN
  ,output logic [15:0] stall_cnt
`endif
);

  localparam int IW = $clog2(PIPE_LAT + 1);
  localparam logic [3:0] CRED_INIT = 4'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic [3:0]          credits_q, credits_d;
  logic [PIPE_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [PIPE_LAT-1:0] src_pipe_q, src_pipe_d;
  logic                rom_en_q, rom_en_d;
  logic [9:0]          rom_addr_q, rom_addr_d;
  logic                rom_wen_q, rom_wen_d;
  logic                buf_wen_q, buf_wen_d;
  logic [2:0]          buf_qua_q, buf_qua_d;
  logic [6:0]          buf_cor_q, buf_cor_d;
`ifdef CSCHED_PERF_EN
  logic [15:0]         stall_q, stall_d;
`endif

  logic any_v, can_issue, gnt1, pop_eff, res_vld;

  // Arbitration: on contention grant the requester that was not granted last.
  always_comb begin
    any_v      = req0_valid | req1_valid;
    can_issue  = (state_q != S_DRAIN) && !flush && (credits_q != 4'd0) && any_v;
    gnt1       = (req0_valid && req1_valid) ? !rr_q : req1_valid;
    req0_ready = can_issue && !gnt1;
    req1_ready = can_issue && gnt1;
  end

  // Datapath: ROM address stage, ROM buffer stage, valid/source shift register.
  always_comb begin
    rom_en_d   = can_issue;
    rom_addr_d = rom_addr_q;
    rom_wen_d  = 1'b0;
    if (can_issue) begin
      rom_addr_d = gnt1 ? {req1_qua, req1_cor} : {req0_qua, req0_cor};
      rom_wen_d  = gnt1 ? req1_wen : req0_wen;
    end
    // Buffer sees zeros when no token is presented so wen stays low.
    buf_wen_d  = rom_en_q & rom_wen_q;
    buf_qua_d  = rom_en_q ? rom_addr_q[9:7] : 3'd0;
    buf_cor_d  = rom_en_q ? rom_addr_q[6:0] : 7'd0;
    vld_pipe_d = {vld_pipe_q[PIPE_LAT-2:0], can_issue};
    src_pipe_d = {src_pipe_q[PIPE_LAT-2:0], can_issue & gnt1};
    rr_d       = can_issue ? gnt1 : rr_q;
  end

  // Credit and in-flight bookkeeping; a pop at full credit is dropped.
  always_comb begin
    res_vld    = vld_pipe_q[PIPE_LAT-1];
    pop_eff    = res_pop && (credits_q != CRED_INIT);
    credits_d  = credits_q;
    if (can_issue && !pop_eff)      credits_d = credits_q - 4'd1;
    else if (pop_eff && !can_issue) credits_d = credits_q + 4'd1;
    inflight_d = inflight_q;
    if (can_issue && !res_vld)      inflight_d = inflight_q + IW'(1);
    else if (res_vld && !can_issue) inflight_d = inflight_q - IW'(1);
  end

  // Control state: drain completes on the cycle the last token leaves.
  always_comb begin
    state_d    = state_q;
    flush_done = (state_q == S_DRAIN) && (inflight_d == '0);
    case (state_q)
      S_IDLE:  if (flush) state_d = S_DRAIN;
               else if (any_v) state_d = S_RUN;
      S_RUN:   if (flush) state_d = S_DRAIN;
               else if ((inflight_d == '0) && !any_v) state_d = S_IDLE;
      S_DRAIN: if (inflight_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CSCHED_PERF_EN
  // Count cycles where someone wants to issue but cannot; saturating.
  always_comb begin
    stall_d = stall_q;
    if (any_v && !can_issue && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`endif

  // All state registers; reset discards every in-flight token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      inflight_q <= '0;
      credits_q  <= CRED_INIT;
      vld_pipe_q <= '0;
      src_pipe_q <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= 10'd0;
      rom_wen_q  <= 1'b0;
      buf_wen_q  <= 1'b0;
      buf_qua_q  <= 3'd0;
      buf_cor_q  <= 7'd0;
`ifdef CSCHED_PERF_EN
      stall_q    <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      inflight_q <= inflight_d;
      credits_q  <= credits_d;
      vld_pipe_q <= vld_pipe_d;
      src_pipe_q <= src_pipe_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      rom_wen_q  <= rom_wen_d;
      buf_wen_q  <= buf_wen_d;
      buf_qua_q  <= buf_qua_d;
      buf_cor_q  <= buf_cor_d;
`ifdef CSCHED_PERF_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign buf_wen   = buf_wen_q;
  assign buf_qua   = buf_qua_q;
  assign buf_cor   = buf_cor_q;
  assign res_valid = res_vld;
  assign res_src   = res_vld & src_pipe_q[PIPE_LAT-1];
  assign credits   = credits_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cordic_pipe_sched.sv
// Directed bench for cordic_pipe_sched with a scoreboard of expected results.
module tb_cordic_pipe_sched;
  localparam int PIPE_LAT = 12;
  localparam int CREDITS  = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_wen = 0, req1_wen = 0;
  logic [2:0] req0_qua = 0, req1_qua = 0;
  logic [6:0] req0_cor = 0, req1_cor = 0;
  logic flush = 0, res_pop = 0;
  logic req0_ready, req1_ready, rom_en, buf_wen, res_valid, res_src, busy, flush_done;
  logic [9:0] rom_addr;
  logic [2:0] buf_qua;
  logic [6:0] buf_cor;
  logic [3:0] credits;
`ifdef CSCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  cordic_pipe_sched #(.PIPE_LAT(PIPE_LAT), .CREDITS(CREDITS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_qua(req0_qua),
    .req0_cor(req0_cor), .req0_wen(req0_wen),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_qua(req1_qua),
    .req1_cor(req1_cor), .req1_wen(req1_wen),
    .flush(flush), .rom_en(rom_en), .rom_addr(rom_addr),
    .buf_wen(buf_wen), .buf_qua(buf_qua), .buf_cor(buf_cor),
    .res_valid(res_valid), .res_src(res_src), .res_pop(res_pop),
    .credits(credits), .busy(busy), .flush_done(flush_done)
`ifdef CSCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct { bit src; int due; } tok_t;
  tok_t sb[$];
  int checks = 0, fails = 0, cyc = 0, fd_seen = 0;
  int m_cred = CREDITS;
  bit m_rr = 0, m_drain = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // advance the model, then return 1 time unit after the next rising edge.
  task automatic cycle();
    tok_t t;
    bit exp_res, can, g, pop_eff, drain_now, fd;
    @(negedge clk);
    drain_now = m_drain;
    exp_res = (sb.size() > 0) && (sb[0].due == cyc);
    chk("res_valid", res_valid, exp_res);
    if (exp_res) begin
      chk("res_src", res_src, sb[0].src);
      void'(sb.pop_front());
    end
    fd = drain_now && (sb.size() == 0);
    chk("flush_done", flush_done, fd);
    if (fd) begin m_drain = 0; fd_seen++; end
    chk("credits", credits, m_cred);
    can = !drain_now && !flush && (m_cred != 0) && (req0_valid || req1_valid);
    g = (req0_valid && req1_valid) ? !m_rr : req1_valid;
    chk("req0_ready", req0_ready, can && !g);
    chk("req1_ready", req1_ready, can && g);
    if (can) begin t.src = g; t.due = cyc + PIPE_LAT; sb.push_back(t); m_rr = g; end
    pop_eff = res_pop && (m_cred != CREDITS);
    if (can && !pop_eff) m_cred--;
    else if (pop_eff && !can) m_cred++;
    if (flush && !m_drain && !fd) m_drain = 1;
    @(posedge clk); cyc++; #1;
  endtask

  task automatic drain_all(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credits", credits, CREDITS);
    reset = 0;
    @(posedge clk); #1;

    // 1: single req0 token
    req0_valid = 1; req0_qua = 3'd3; req0_cor = 7'h15; req0_wen = 1;
    cycle();
    req0_valid = 0; req0_qua = 0; req0_cor = 0; req0_wen = 0;
    chk("t1_rom_en", rom_en, 1);
    chk("t1_rom_addr", rom_addr, 10'h195);
    chk("t1_credits", credits, 7);
    cycle();
    chk("t1_buf_wen", buf_wen, 1);
    chk("t1_buf_qua", buf_qua, 3);
    chk("t1_buf_cor", buf_cor, 7'h15);
    chk("t1_rom_en_off", rom_en, 0);
    chk("t1_rom_addr_hold", rom_addr, 10'h195);
    cycle();
    chk("t1_buf_idle", {buf_wen, buf_qua, buf_cor}, 0);
    drain_all(20);
    res_pop = 1; cycle(); res_pop = 0;
    chk("t1_credit_back", credits, CREDITS);
    cycle();

    // 2: contention, alternating grants, res_pop tied high
    res_pop = 1; req0_valid = 1; req1_valid = 1;
    req0_qua = 3'd1; req0_cor = 7'h2A; req1_qua = 3'd6; req1_cor = 7'h07;
    repeat (6) cycle();
    req0_valid = 0; req1_valid = 0;
    drain_all(20);
    repeat (3) cycle();
    chk("t2_idle_busy", busy, 0);
    chk("t2_credits", credits, CREDITS);

    // 3: credit exhaustion with res_pop low, then one pop frees one issue
    res_pop = 0; req0_valid = 1; req1_valid = 1;
    repeat (10) cycle();
    chk("t3_credits0", credits, 0);
    res_pop = 1; cycle(); res_pop = 0;
    repeat (3) cycle();
    req0_valid = 0; req1_valid = 0; res_pop = 1;
    drain_all(20);
    repeat (10) cycle();
    chk("t3_refill", credits, CREDITS);

    // 4: flush after 4 issues, requests held during drain
    req0_valid = 1;
    repeat (4) cycle();
    flush = 1; cycle(); flush = 0;
    chk("t4_busy_drain", busy, 1);
    fd_seen = 0;
    drain_all(20);
    req0_valid = 0;
    cycle();
    chk("t4_fd_once", fd_seen, 1);
    chk("t4_idle", busy, 0);
    // flush in IDLE with empty pipe
    flush = 1; cycle(); flush = 0;
    cycle();
    chk("t4_fd_idle", fd_seen, 2);
    cycle();
    chk("t4_idle2", busy, 0);

    // 5: reset with 5 tokens in flight
    req0_valid = 1;
    repeat (5) cycle();
    req0_valid = 0; res_pop = 0;
    reset = 1; #1;
    chk("t5_rom_en", rom_en, 0);
    chk("t5_rom_addr", rom_addr, 0);
    chk("t5_buf", {buf_wen, buf_qua, buf_cor}, 0);
    chk("t5_res", {res_valid, res_src}, 0);
    chk("t5_busy", busy, 0);
    chk("t5_credits", credits, CREDITS);
    @(posedge clk); cyc++; #1;
    reset = 0;
    sb.delete(); m_cred = CREDITS; m_rr = 0; m_drain = 0;
    repeat (20) cycle();

`ifdef CSCHED_PERF_EN
    // 6: stall counter with credits exhausted
    req0_valid = 1;
    repeat (CREDITS + 20) cycle();
    chk("t6_stall_cnt", stall_cnt, 20);
    req0_valid = 0; res_pop = 1;
    drain_all(20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
